ram_cycle_ctrl: RTL and testbench

Clocked sequencer for the CPC 512K RAM expansion. It tracks each Z80 memory cycle through a small state machine and generates SRAM strobes and the write-cycle window used for RD*/A15 overdrive. It also captures bank-select writes to 0x7Fxx (0b11cccbbb) and commits them only between memory cycles, so a bank switch never lands mid-access. It sits between the CPC bus pins and the bank-mapping logic, which consumes `ramblock` and `mwr_cyc`.

---
 rtl/ram_exp_pkg.sv | 26 ++
 rtl/ram_cycle_ctrl_if.sv | 31 +++
 rtl/ram_cfg_capture.sv | 52 +++++
 rtl/ram_cycle_ctrl.sv | 104 ++++++++++
 tb/tb_ram_cycle_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_exp_pkg.sv
// Shared types and constants for the CPC 512K RAM expansion: cycle-FSM state
// encoding and the bank-select port decode values.
package ram_exp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_RD    = 3'b001,
    ST_WR_T1 = 3'b010,
    ST_WR_T2 = 3'b011,
    ST_END   = 3'b100
  } cyc_state_t;

  // Bank-select writes go to 0x7Fxx with data 0b11cccbbb.
  localparam logic [1:0] CFG_TAG      = 2'b11;
  localparam logic       CFG_PORT_A15 = 1'b0;

  // True between memory cycles, the only place a new bank config may land.
  function automatic logic is_gap(cyc_state_t s);
    return (s == ST_IDLE) || (s == ST_END);
  endfunction

  function automatic logic is_write(cyc_state_t s);
    return (s == ST_WR_T1) || (s == ST_WR_T2);
  endfunction

endpackage

// File: rtl/ram_cycle_ctrl_if.sv
// CPC expansion-port bus as seen by the RAM cycle controller: Z80 controls,
// address/data in, SRAM strobes and bank config out.
interface ram_cycle_ctrl_if;
  logic       mreq_b;
  logic       iorq_b;
  logic       rfsh_b;
  logic       rd_b;
  logic       wr_b;
  logic       ready;
  logic       adr15;
  logic       adr14;
  logic [7:0] data;

  logic [5:0] ramblock;
  logic       cfg_pending;
  logic       mwr_cyc;
  logic       ramoe_b;
  logic       ramwe_b;
  logic       wait_timeout;

  // master drives the Z80 side of the bus; slave is the cycle controller.
  modport master (
    output mreq_b, iorq_b, rfsh_b, rd_b, wr_b, ready, adr15, adr14, data,
    input  ramblock, cfg_pending, mwr_cyc, ramoe_b, ramwe_b, wait_timeout
  );

  modport slave (
    input  mreq_b, iorq_b, rfsh_b, rd_b, wr_b, ready, adr15, adr14, data,
    output ramblock, cfg_pending, mwr_cyc, ramoe_b, ramwe_b, wait_timeout
  );
endinterface

// File: rtl/ram_cfg_capture.sv
// Bank-select capture: detects the I/O write to 0x7Fxx, holds the value as
// pending, and commits it to ramblock only when the cycle FSM allows.
module ram_cfg_capture
  import ram_exp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       adr15,
  input  logic [7:0] data,
  input  logic       commit_ok,
  output logic [5:0] ramblock,
  output logic       cfg_pending
);

  logic       iorq_b_q;
  logic [5:0] pend_q;
  logic [5:0] ramblock_q;
  logic       pending_q;
  logic       cfg_hit;
  logic       commit;

  assign cfg_hit = !iorq_b && iorq_b_q && !wr_b
                   && (adr15 == CFG_PORT_A15) && (data[7:6] == CFG_TAG);
  assign commit  = pending_q && commit_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      iorq_b_q   <= 1'b1;
      pend_q     <= '0;
      pending_q  <= 1'b0;
      ramblock_q <= '0;
    end else begin
      iorq_b_q <= iorq_b;
      // NOTE: non-blocking assignment lets a commit read the old pend_q on the
      // same edge a new capture overwrites it, so neither value is lost.
      if (commit)
        ramblock_q <= pend_q;
      if (cfg_hit) begin
        pend_q    <= data[5:0];
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign ramblock    = ramblock_q;
  assign cfg_pending = pending_q;

endmodule

// File: rtl/ram_cycle_ctrl.sv
// Z80 memory-cycle sequencer for the CPC 512K RAM expansion: tracks each
// memory cycle, drives SRAM strobes and the write window, gates bank commits.
module ram_cycle_ctrl
  import ram_exp_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  ram_cycle_ctrl_if.slave  bus
);

  cyc_state_t       state;
  cyc_state_t       nxt;
  logic             mreq_b_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             start;
  logic             wait_expired;
  logic             commit_ok;
  logic             ramoe_q;
  logic             ramwe_q;
  logic             mwr_q;
  logic             timeout_q;
  logic             unused_adr14;

  assign unused_adr14 = bus.adr14;

  // Falling edge of MREQ outside refresh opens a new memory cycle.
  assign start        = !bus.mreq_b && mreq_b_q && bus.rfsh_b;
  assign wait_expired = !bus.ready && (wait_cnt == CNT_W'(WAIT_LIMIT));
  assign commit_ok    = is_gap(state) && !start;

  always_comb begin
    // NOTE: default first, so every path assigns nxt and no latch is inferred.
    nxt = state;
    unique case (state)
      ST_IDLE, ST_END: begin
        if (start)
          nxt = bus.rd_b ? ST_WR_T1 : ST_RD;
        else
          nxt = ST_IDLE;
      end
      ST_RD: begin
        if (bus.mreq_b)
          nxt = ST_END;
      end
      ST_WR_T1: begin
        if (bus.ready)
          nxt = ST_WR_T2;
        else if (wait_expired)
          nxt = ST_END;
      end
      ST_WR_T2: nxt = ST_END;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so they track the state
  // register exactly and carry no combinational path from the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mreq_b_q  <= 1'b1;
      wait_cnt  <= '0;
      ramoe_q   <= 1'b1;
      ramwe_q   <= 1'b1;
      mwr_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state    <= nxt;
      mreq_b_q <= bus.mreq_b;
      ramoe_q  <= (nxt != ST_RD);
      ramwe_q  <= !is_write(nxt);
      mwr_q    <= is_write(nxt);

      if (nxt == ST_WR_T1 && state != ST_WR_T1)
        wait_cnt <= '0;
      else if (state == ST_WR_T1 && !bus.ready && wait_cnt != CNT_W'(WAIT_LIMIT))
        wait_cnt <= wait_cnt + CNT_W'(1);

      if (state == ST_WR_T1 && wait_expired)
        timeout_q <= 1'b1;
    end
  end

  ram_cfg_capture u_cfg (
    .clk         (clk),
    .reset       (reset),
    .iorq_b      (bus.iorq_b),
    .wr_b        (bus.wr_b),
    .adr15       (bus.adr15),
    .data        (bus.data),
    .commit_ok   (commit_ok),
    .ramblock    (bus.ramblock),
    .cfg_pending (bus.cfg_pending)
  );

  assign bus.ramoe_b      = ramoe_q;
  assign bus.ramwe_b      = ramwe_q;
  assign bus.mwr_cyc      = mwr_q;
  assign bus.wait_timeout = timeout_q;

endmodule

// File: tb/tb_ram_cycle_ctrl.sv
// Directed bench for ram_cycle_ctrl: inputs change and outputs are sampled on
// the falling clock edge, away from the rising edge the design uses.
module tb_ram_cycle_ctrl;
  import ram_exp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ram_cycle_ctrl_if bus ();

  ram_cycle_ctrl #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.mreq_b = 1'b1; bus.iorq_b = 1'b1; bus.rfsh_b = 1'b1;
    bus.rd_b   = 1'b1; bus.wr_b   = 1'b1; bus.ready  = 1'b1;
    bus.adr15  = 1'b1; bus.adr14  = 1'b0; bus.data   = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_idle();
    tick(2);
    reset = 1'b0;
    tick(1);
    total++;
    if ({bus.ramoe_b, bus.ramwe_b, bus.mwr_cyc, bus.wait_timeout} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_strobes: got oe/we/mwr/to=%b want 1100",
               {bus.ramoe_b, bus.ramwe_b, bus.mwr_cyc, bus.wait_timeout});
    end
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== 7'h00) begin
      bad++;
      $display("FAIL reset_cfg: got ramblock=%h pending=%b want 00/0", bus.ramblock, bus.cfg_pending);
    end
  endtask

  task automatic test_read();
    bus.mreq_b = 1'b0; bus.rd_b = 1'b0;
    tick(1);
    total++;
    if ({bus.ramoe_b, bus.ramwe_b} !== 2'b01) begin
      bad++;
      $display("FAIL read_strobe_on: got oe/we=%b want 01", {bus.ramoe_b, bus.ramwe_b});
    end
    tick(1);
    total++;
    if (bus.ramoe_b !== 1'b0) begin
      bad++;
      $display("FAIL read_strobe_hold: got oe=%b want 0", bus.ramoe_b);
    end
    bus.mreq_b = 1'b1; bus.rd_b = 1'b1;
    tick(1);
    total++;
    if ({bus.ramoe_b, bus.ramwe_b} !== 2'b11 || dut.state !== ST_END) begin
      bad++;
      $display("FAIL read_end: got oe/we=%b state=%0d want 11 state=%0d",
               {bus.ramoe_b, bus.ramwe_b}, dut.state, ST_END);
    end
    tick(1);
    total++;
    if (dut.state !== ST_IDLE) begin
      bad++;
      $display("FAIL read_idle: got state=%0d want %0d", dut.state, ST_IDLE);
    end
  endtask

  task automatic test_write_wait();
    int mwr_n = 0;
    int we_n  = 0;
    bus.mreq_b = 1'b0; bus.rd_b = 1'b1; bus.wr_b = 1'b0; bus.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.mwr_cyc === 1'b1) mwr_n++;
      if (bus.ramwe_b === 1'b0) we_n++;
      if (i == 2) bus.ready = 1'b1;
      if (i == 4) bus_idle();
    end
    total++;
    if (mwr_n != 4 || we_n != 4) begin
      bad++;
      $display("FAIL write_window: got mwr=%0d we=%0d clocks want 4/4", mwr_n, we_n);
    end
    total++;
    if (bus.wait_timeout !== 1'b0 || dut.state !== ST_IDLE) begin
      bad++;
      $display("FAIL write_done: got timeout=%b state=%0d want 0/%0d",
               bus.wait_timeout, dut.state, ST_IDLE);
    end
  endtask

  task automatic test_idle_commit();
    bus.iorq_b = 1'b0; bus.wr_b = 1'b0; bus.adr15 = 1'b0; bus.data = 8'hC9;
    tick(1);
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== {6'h00, 1'b1}) begin
      bad++;
      $display("FAIL idle_capture: got ramblock=%h pending=%b want 00/1", bus.ramblock, bus.cfg_pending);
    end
    bus_idle();
    tick(1);
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== {6'h09, 1'b0}) begin
      bad++;
      $display("FAIL idle_commit: got ramblock=%h pending=%b want 09/0", bus.ramblock, bus.cfg_pending);
    end
  endtask

  task automatic test_decode_reject();
    logic [7:0] d [3]   = '{8'h82, 8'hC3, 8'hC3};
    logic       a15 [3] = '{1'b0, 1'b1, 1'b0};
    logic       wr [3]  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bus.iorq_b = 1'b0; bus.data = d[i]; bus.adr15 = a15[i]; bus.wr_b = wr[i];
      tick(1);
      bus_idle();
      tick(1);
      total++;
      if ({bus.ramblock, bus.cfg_pending} !== {6'h09, 1'b0}) begin
        bad++;
        $display("FAIL decode_reject_%0d: got ramblock=%h pending=%b want 09/0",
                 i, bus.ramblock, bus.cfg_pending);
      end
    end
  endtask

  task automatic test_cfg_during_write();
    bus.mreq_b = 1'b0; bus.rd_b = 1'b1; bus.wr_b = 1'b0; bus.ready = 1'b0;
    tick(1);
    bus.iorq_b = 1'b0; bus.adr15 = 1'b0; bus.data = 8'hD2;
    tick(1);
    total++;
    if ({bus.ramblock, bus.cfg_pending, bus.mwr_cyc} !== {6'h09, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL wcfg_pending: got ramblock=%h pending=%b mwr=%b want 09/1/1",
               bus.ramblock, bus.cfg_pending, bus.mwr_cyc);
    end
    bus.iorq_b = 1'b1; bus.ready = 1'b1;
    tick(2);
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== {6'h09, 1'b1} || dut.state !== ST_END) begin
      bad++;
      $display("FAIL wcfg_hold: got ramblock=%h pending=%b state=%0d want 09/1/%0d",
               bus.ramblock, bus.cfg_pending, dut.state, ST_END);
    end
    bus_idle();
    tick(1);
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== {6'h12, 1'b0}) begin
      bad++;
      $display("FAIL wcfg_commit: got ramblock=%h pending=%b want 12/0", bus.ramblock, bus.cfg_pending);
    end
  endtask

  task automatic test_back_to_back();
    logic seen_c1 = 1'b0;
    bus.mreq_b = 1'b0; bus.rd_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (bus.ramblock === 6'h01) seen_c1 = 1'b1;
      case (i)
        0: begin bus.iorq_b = 1'b0; bus.wr_b = 1'b0; bus.adr15 = 1'b0; bus.data = 8'hC1; end
        1: bus.iorq_b = 1'b1;
        2: begin bus.iorq_b = 1'b0; bus.data = 8'hFF; end
        3: begin
          total++;
          if ({bus.ramblock, bus.cfg_pending} !== {6'h12, 1'b1}) begin
            bad++;
            $display("FAIL b2b_pending: got ramblock=%h pending=%b want 12/1",
                     bus.ramblock, bus.cfg_pending);
          end
          bus_idle();
        end
        default: ;
      endcase
    end
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== {6'h3F, 1'b0}) begin
      bad++;
      $display("FAIL b2b_commit: got ramblock=%h pending=%b want 3f/0", bus.ramblock, bus.cfg_pending);
    end
    total++;
    if (seen_c1 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_c1: got ramblock=01 seen=%b want 0", seen_c1);
    end
  endtask

  task automatic test_commit_collision();
    bus.mreq_b = 1'b0; bus.rd_b = 1'b0;
    tick(1);
    bus.iorq_b = 1'b0; bus.wr_b = 1'b0; bus.adr15 = 1'b0; bus.data = 8'hC5;
    tick(1);
    bus.iorq_b = 1'b1; bus.mreq_b = 1'b1; bus.rd_b = 1'b1;
    tick(1);
    bus.iorq_b = 1'b0; bus.data = 8'hE7;
    tick(1);
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== {6'h05, 1'b1}) begin
      bad++;
      $display("FAIL collide_first: got ramblock=%h pending=%b want 05/1", bus.ramblock, bus.cfg_pending);
    end
    bus_idle();
    tick(1);
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== {6'h27, 1'b0}) begin
      bad++;
      $display("FAIL collide_second: got ramblock=%h pending=%b want 27/0", bus.ramblock, bus.cfg_pending);
    end
  endtask

  task automatic test_refresh();
    bus.mreq_b = 1'b0; bus.rfsh_b = 1'b0; bus.rd_b = 1'b0;
    tick(3);
    total++;
    if (dut.state !== ST_IDLE || bus.ramoe_b !== 1'b1) begin
      bad++;
      $display("FAIL refresh_ignored: got state=%0d oe=%b want %0d/1", dut.state, bus.ramoe_b, ST_IDLE);
    end
    bus_idle();
    tick(1);
  endtask

  task automatic test_timeout();
    int mwr_n = 0;
    int first_to = -1;
    bus.mreq_b = 1'b0; bus.rd_b = 1'b1; bus.wr_b = 1'b0; bus.ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.mwr_cyc === 1'b1) mwr_n++;
      if (bus.wait_timeout === 1'b1 && first_to < 0) first_to = i;
      if (i == 17) bus_idle();
    end
    total++;
    if (mwr_n != 16) begin
      bad++;
      $display("FAIL timeout_window: got %0d clocks want 16", mwr_n);
    end
    total++;
    if (first_to != 16) begin
      bad++;
      $display("FAIL timeout_flag_edge: got first set at clock %0d want 16", first_to);
    end
    tick(5);
    total++;
    if (bus.wait_timeout !== 1'b1 || dut.state !== ST_IDLE) begin
      bad++;
      $display("FAIL timeout_sticky: got timeout=%b state=%0d want 1/%0d",
               bus.wait_timeout, dut.state, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.mreq_b = 1'b0; bus.rd_b = 1'b1; bus.wr_b = 1'b0; bus.ready = 1'b0;
    tick(1);
    bus.iorq_b = 1'b0; bus.adr15 = 1'b0; bus.data = 8'hEA;
    tick(1);
    total++;
    if ({bus.cfg_pending, bus.mwr_cyc} !== 2'b11) begin
      bad++;
      $display("FAIL rst_setup: got pending/mwr=%b want 11", {bus.cfg_pending, bus.mwr_cyc});
    end
    bus.iorq_b = 1'b1;
    reset = 1'b1;
    tick(1);
    total++;
    if ({bus.ramblock, bus.cfg_pending, bus.ramoe_b, bus.ramwe_b, bus.mwr_cyc, bus.wait_timeout}
        !== {6'h00, 5'b01100} || dut.state !== ST_IDLE) begin
      bad++;
      $display("FAIL rst_mid_write: got ramblock=%h pend/oe/we/mwr/to=%b state=%0d want 00/01100/%0d",
               bus.ramblock, {bus.cfg_pending, bus.ramoe_b, bus.ramwe_b, bus.mwr_cyc, bus.wait_timeout},
               dut.state, ST_IDLE);
    end
    reset = 1'b0;
    bus_idle();
    tick(2);
    total++;
    if ({bus.ramblock, bus.cfg_pending} !== 7'h00) begin
      bad++;
      $display("FAIL rst_discard: got ramblock=%h pending=%b want 00/0", bus.ramblock, bus.cfg_pending);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_idle_commit();
    test_decode_reject();
    test_cfg_during_write();
    test_back_to_back();
    test_commit_collision();
    test_refresh();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 time units");
    $fatal(1);
  end

endmodule
